multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath: sequences fetch,
// decode and the per-opcode execute/memory/writeback steps.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ins,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Reg_Dst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHL  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  state_t cur, nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Next-state logic; encodings 12-15 fall through to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ins)
          OP_RTYPE:     nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (ins == OP_LW)      nxt = S_MEM_RD;
        else if (ins == OP_SW) nxt = S_MEM_WR;
        else                   nxt = S_FETCH;
      end
      S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     nxt = S_R_WB;
      S_ADDI_EX:  nxt = S_ADDI_WB;
      default:    nxt = S_FETCH;
    endcase
  end

  // Output logic; everything is forced low while rst is held so that
  // mem_ready-qualified strobes cannot fire during reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Reg_Dst     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCS_ALU;
    ALUOp       = ALU_ADD;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_SHL;
          case (ins)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                        illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          Reg_Dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCS_ALUOUT;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCS_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: the driver queues the expected
// state/control word per cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ins;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, Reg_Dst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .ins(ins), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Reg_Dst(Reg_Dst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_done(instr_done),
    .state(state)
  );

  always #5 clk = ~clk;

  // Control word: PCW PCWC IorD MRd MWr IRW M2R RW RD ASA _ ASB _ PCS _ OP _ ILL DONE
  localparam logic [18:0] O_ZERO    = 19'b0000000000_00_00_000_00;
  localparam logic [18:0] O_FETCH_R = 19'b1001010000_01_00_000_00;
  localparam logic [18:0] O_FETCH_W = 19'b0001000000_01_00_000_00;
  localparam logic [18:0] O_DECODE  = 19'b0000000000_11_00_000_00;
  localparam logic [18:0] O_DEC_ILL = 19'b0000000000_11_00_000_10;
  localparam logic [18:0] O_ADDR    = 19'b0000000001_10_00_000_00;
  localparam logic [18:0] O_MEM_RD  = 19'b0011000000_00_00_000_00;
  localparam logic [18:0] O_MEM_WB  = 19'b0000001100_00_00_000_01;
  localparam logic [18:0] O_MEMWR_W = 19'b0010100000_00_00_000_00;
  localparam logic [18:0] O_MEMWR_R = 19'b0010100000_00_00_000_01;
  localparam logic [18:0] O_EXEC    = 19'b0000000001_00_00_010_00;
  localparam logic [18:0] O_R_WB    = 19'b0000000110_00_00_000_01;
  localparam logic [18:0] O_ADDI_WB = 19'b0000000100_00_00_000_01;
  localparam logic [18:0] O_BRANCH  = 19'b0100000001_00_01_001_01;
  localparam logic [18:0] O_JUMP    = 19'b1000000000_00_10_000_01;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [18:0] outs;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;

  wire [18:0] act_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                          MemtoReg, RegWrite, Reg_Dst, ALUSrcA, ALUSrcB, PCSource,
                          ALUOp, illegal_op, instr_done};

  // Monitor: the DUT presents a control word every cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (state !== e.st || act_outs !== e.outs) begin
        n_err++;
        $display("FAIL vec%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 e.idx, state, act_outs, e.st, e.outs);
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] est, input logic [18:0] eout);
    exp_t e;
    rst = r; ins = op; mem_ready = mr;
    e.idx = n_push; e.st = est; e.outs = eout;
    q.push_back(e);
    n_push++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ins = RT; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, RT, 1, 4'd0, O_ZERO);        // reset overrides mem_ready
    // lw
    cyc(0, LW, 1, 4'd0, O_FETCH_R);
    cyc(0, LW, 1, 4'd1, O_DECODE);
    cyc(0, LW, 1, 4'd2, O_ADDR);
    cyc(0, LW, 1, 4'd3, O_MEM_RD);
    cyc(0, LW, 1, 4'd4, O_MEM_WB);
    // R-type with one fetch wait
    cyc(0, RT, 0, 4'd0, O_FETCH_W);
    cyc(0, RT, 1, 4'd0, O_FETCH_R);
    cyc(0, RT, 1, 4'd1, O_DECODE);
    cyc(0, RT, 1, 4'd6, O_EXEC);
    cyc(0, RT, 1, 4'd7, O_R_WB);
    // sw with 3 wait cycles
    cyc(0, SW, 1, 4'd0, O_FETCH_R);
    cyc(0, SW, 1, 4'd1, O_DECODE);
    cyc(0, SW, 1, 4'd2, O_ADDR);
    for (int i = 0; i < 3; i++) cyc(0, SW, 0, 4'd5, O_MEMWR_W);
    cyc(0, SW, 1, 4'd5, O_MEMWR_R);
    // beq then j
    cyc(0, BEQ, 1, 4'd0, O_FETCH_R);
    cyc(0, BEQ, 1, 4'd1, O_DECODE);
    cyc(0, BEQ, 1, 4'd8, O_BRANCH);
    cyc(0, J, 1, 4'd0, O_FETCH_R);
    cyc(0, J, 1, 4'd1, O_DECODE);
    cyc(0, J, 1, 4'd9, O_JUMP);
    // addi
    cyc(0, ADDI, 1, 4'd0, O_FETCH_R);
    cyc(0, ADDI, 1, 4'd1, O_DECODE);
    cyc(0, ADDI, 1, 4'd10, O_ADDR);
    cyc(0, ADDI, 1, 4'd11, O_ADDI_WB);
    // illegal opcode
    cyc(0, BAD, 1, 4'd0, O_FETCH_R);
    cyc(0, BAD, 1, 4'd1, O_DEC_ILL);
    // lw interrupted by reset while waiting in MEM_RD
    cyc(0, LW, 1, 4'd0, O_FETCH_R);
    cyc(0, LW, 1, 4'd1, O_DECODE);
    cyc(0, LW, 1, 4'd2, O_ADDR);
    cyc(0, LW, 0, 4'd3, O_MEM_RD);
    cyc(1, LW, 0, 4'd3, O_ZERO);
    cyc(1, LW, 1, 4'd0, O_ZERO);
    cyc(0, LW, 1, 4'd0, O_FETCH_R);
    cyc(0, LW, 1, 4'd1, O_DECODE);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
